// File: rtl/echo_pkg.sv
// Shared types and constants for the ultrasonic echo measurement path.
// Ranging-cycle timing references live here so the trigger generator agrees with them.
package echo_pkg;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_RISE = 2'd1,
    MEASURE   = 2'd2,
    HOLD      = 2'd3
  } echo_state_t;

  // 10 us trigger at 27 MHz
  localparam int TRIG_CYC = 270;

endpackage

// File: rtl/echo_capture_if.sv
// Echo capture bus: raw echo and arm in, width result out over valid/ready.
// master = measuring block, slave = consumer / trigger side.
interface echo_capture_if #(
  parameter int WIDTH_W = 32
);
  logic               echo_pin;
  logic               arm;
  logic               result_ready;
  logic               result_valid;
  logic [WIDTH_W-1:0] width_out;
  logic               timeout_flag;
  logic               busy;
  logic               echo_clean;

  modport master (
    input  echo_pin, arm, result_ready,
    output result_valid, width_out, timeout_flag, busy, echo_clean
  );

  modport slave (
    output echo_pin, arm, result_ready,
    input  result_valid, width_out, timeout_flag, busy, echo_clean
  );
endinterface

// File: rtl/echo_glitch_filter.sv
// Debounce: q follows d only after FILTER_LEN consecutive disagreeing samples.
// Any shorter disagreement is discarded and the run counter restarts.
module echo_glitch_filter #(
  parameter int FILTER_LEN = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  localparam int CNT_W = $clog2(FILTER_LEN + 1);

  logic             q_q, q_d;
  logic [CNT_W-1:0] run_q, run_d;

  always_comb begin
    q_d   = q_q;
    run_d = '0;
    if (d != q_q) begin
      if (run_q == CNT_W'(FILTER_LEN - 1)) begin
        q_d = d;
      end else begin
        run_d = run_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q_q   <= 1'b0;
      run_q <= '0;
    end else begin
      q_q   <= q_d;
      run_q <= run_d;
    end
  end

  assign q = q_q;
endmodule

// File: rtl/echo_capture.sv
// Synchronizes and optionally filters the echo (ECHO_GLITCH_FILTER_EN), then measures one
// high pulse per arm with a saturating, timeout-bounded counter; result held until accepted.
module echo_capture
  import echo_pkg::*;
#(
  parameter int CLK_HZ      = 27_000_000,
  parameter int WIDTH_W     = 32,
  parameter int FILTER_LEN  = 16,
  parameter int TIMEOUT_CYC = 1_000_000
) (
  input logic            clk,
  input logic            rst,
  echo_capture_if.master bus
);
  localparam logic [WIDTH_W-1:0] TMO = WIDTH_W'(TIMEOUT_CYC);

  if (CLK_HZ < 1 || FILTER_LEN < 1 || TIMEOUT_CYC < 1 ||
      WIDTH_W < $clog2(TIMEOUT_CYC + 1)) begin : g_bad_cfg
    $error("echo_capture: invalid parameter set");
  end

  logic               sync1_q, sync1_d;
  logic               sync2_q, sync2_d;
  logic               prev_q, prev_d;
  logic               echo_clean;
  echo_state_t        state_q, state_d;
  logic [WIDTH_W-1:0] cnt_q, cnt_d;
  logic [WIDTH_W-1:0] width_q, width_d;
  logic               tflag_q, tflag_d;
  logic [WIDTH_W-1:0] cnt_inc;
  logic               rise, fall;

`ifdef ECHO_GLITCH_FILTER_EN
  echo_glitch_filter #(.FILTER_LEN(FILTER_LEN)) u_filter (
    .clk (clk),
    .rst (rst),
    .d   (sync2_q),
    .q   (echo_clean)
  );
`else
  assign echo_clean = sync2_q;
`endif

  assign rise    = echo_clean & ~prev_q;
  assign fall    = ~echo_clean & prev_q;
  assign cnt_inc = cnt_q + 1'b1;

  always_comb begin
    sync1_d = bus.echo_pin;
    sync2_d = sync1_q;
    prev_d  = echo_clean;
    state_d = state_q;
    cnt_d   = cnt_q;
    width_d = width_q;
    tflag_d = tflag_q;
    unique case (state_q)
      IDLE: begin
        if (bus.arm) begin
          state_d = WAIT_RISE;
          cnt_d   = '0;
        end
      end
      WAIT_RISE: begin
        // A level already high at arm time has no rise edge, so it is never measured
        if (rise) begin
          state_d = MEASURE;
          cnt_d   = WIDTH_W'(1);
        end else if (cnt_inc == TMO) begin
          state_d = HOLD;
          cnt_d   = TMO;
          width_d = '0;
          tflag_d = 1'b1;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      MEASURE: begin
        if (fall) begin
          state_d = HOLD;
          width_d = cnt_q;
          tflag_d = 1'b0;
        end else if (echo_clean) begin
          cnt_d = cnt_inc;
          if (cnt_inc == TMO) begin
            state_d = HOLD;
            width_d = TMO;
            tflag_d = 1'b1;
          end
        end
      end
      HOLD: begin
        if (bus.result_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      width_q <= '0;
      tflag_q <= 1'b0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      prev_q  <= prev_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      width_q <= width_d;
      tflag_q <= tflag_d;
    end
  end

  assign bus.result_valid = (state_q == HOLD);
  assign bus.busy         = (state_q != IDLE);
  assign bus.width_out    = width_q;
  assign bus.timeout_flag = tflag_q;
  assign bus.echo_clean   = echo_clean;
endmodule

// File: tb/tb_echo_capture.sv
// Directed bench: a long-timeout DUT for width measurements and a TIMEOUT_CYC=1000 DUT
// for timeout behaviour, both driven from the same stimulus.
module tb_echo_capture;
  import echo_pkg::*;

`ifdef ECHO_GLITCH_FILTER_EN
  localparam int   GLITCH_W = 5000;
  localparam int   SPIKE_W  = 0;
  localparam logic SPIKE_TO = 1'b1;
`else
  localparam int   GLITCH_W = 700;
  localparam int   SPIKE_W  = 10;
  localparam logic SPIKE_TO = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic echo = 1'b0;
  logic arm = 1'b0;
  logic rdy = 1'b1;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  echo_capture_if #(.WIDTH_W(32)) bl ();
  echo_capture_if #(.WIDTH_W(32)) bs ();

  assign bl.echo_pin     = echo;
  assign bl.arm          = arm;
  assign bl.result_ready = rdy;
  assign bs.echo_pin     = echo;
  assign bs.arm          = arm;
  assign bs.result_ready = rdy;

  echo_capture #(.CLK_HZ(27_000_000), .WIDTH_W(32), .FILTER_LEN(16), .TIMEOUT_CYC(20000))
    dut_l (.clk(clk), .rst(rst), .bus(bl));
  echo_capture #(.CLK_HZ(27_000_000), .WIDTH_W(32), .FILTER_LEN(16), .TIMEOUT_CYC(1000))
    dut_s (.clk(clk), .rst(rst), .bus(bs));

  task automatic do_reset();
    rst = 1'b0; arm = 1'b0; echo = 1'b0; rdy = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic fire_arm();
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
  endtask

  task automatic pulse(input int n);
    echo = 1'b1;
    repeat (n) @(negedge clk);
    echo = 1'b0;
  endtask

  task automatic wait_valid(input bit sel, input int limit, output int cyc);
    cyc = 0;
    while (!(sel ? bs.result_valid : bl.result_valid) && cyc < limit) begin
      @(negedge clk);
      cyc++;
    end
    if (!(sel ? bs.result_valid : bl.result_valid)) begin
      n_cmp++; n_bad++;
      $display("FAIL wait_valid(dut %0d): no result_valid within %0d cycles", sel, limit);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({bl.result_valid, bl.busy, bl.timeout_flag, bl.echo_clean, bl.width_out} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_l: got v%0b b%0b t%0b c%0b w%0d, want all 0", bl.result_valid,
               bl.busy, bl.timeout_flag, bl.echo_clean, bl.width_out);
    end
    n_cmp++;
    if ({bs.result_valid, bs.busy, bs.timeout_flag, bs.echo_clean, bs.width_out} !== 36'd0) begin
      n_bad++;
      $display("FAIL reset_s: got v%0b b%0b t%0b c%0b w%0d, want all 0", bs.result_valid,
               bs.busy, bs.timeout_flag, bs.echo_clean, bs.width_out);
    end
  endtask

  task automatic test_reset_mid_measure();
    int c;
    do_reset();
    fire_arm();
    repeat (20) @(negedge clk);
    echo = 1'b1;
    repeat (520) @(negedge clk);
    n_cmp++;
    if (bl.busy !== 1'b1 || bl.echo_clean !== 1'b1) begin
      n_bad++;
      $display("FAIL pre_reset_measuring: busy %0b clean %0b, want 1 1", bl.busy, bl.echo_clean);
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({bl.result_valid, bl.busy, bl.timeout_flag, bl.echo_clean, bl.width_out} !== 36'd0) begin
      n_bad++;
      $display("FAIL mid_reset: got v%0b b%0b t%0b c%0b w%0d, want all 0", bl.result_valid,
               bl.busy, bl.timeout_flag, bl.echo_clean, bl.width_out);
    end
    echo = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    fire_arm();
    repeat (20) @(negedge clk);
    pulse(1000);
    wait_valid(1'b0, 100, c);
    n_cmp++;
    if (bl.width_out !== 32'd1000 || bl.timeout_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL after_reset_width: got %0d/t%0b, want 1000/t0", bl.width_out, bl.timeout_flag);
    end
  endtask

  task automatic test_basic();
    int c;
    int n;
    do_reset();
    n_cmp++;
    if (bl.busy !== 1'b0) begin
      n_bad++; $display("FAIL idle_busy: got %0b want 0", bl.busy);
    end
    fire_arm();
    n_cmp++;
    if (bl.busy !== 1'b1) begin
      n_bad++; $display("FAIL arm_to_busy: got %0b want 1", bl.busy);
    end
    repeat (20) @(negedge clk);
    pulse(5400);
    wait_valid(1'b0, 100, c);
    n_cmp++;
    if (bl.width_out !== 32'd5400 || bl.timeout_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_width: got %0d/t%0b, want 5400/t0", bl.width_out, bl.timeout_flag);
    end
    n = 0;
    while (bl.result_valid && n < 10) begin
      n++;
      @(negedge clk);
    end
    n_cmp++;
    if (n !== 1) begin
      n_bad++; $display("FAIL zero_wait_hold: valid for %0d cycles, want 1", n);
    end
    n_cmp++;
    if (bl.busy !== 1'b0) begin
      n_bad++; $display("FAIL busy_after_accept: got %0b want 0", bl.busy);
    end
  endtask

  task automatic test_glitch();
    int c;
    do_reset();
    rdy = 1'b0;
    fire_arm();
    repeat (20) @(negedge clk);
    for (int i = 0; i < 5000; i++) begin
      echo = !(i >= 700 && (i % 700) < 3);
      @(negedge clk);
    end
    echo = 1'b0;
    wait_valid(1'b0, 100, c);
    n_cmp++;
    if (bl.width_out !== 32'(GLITCH_W) || bl.timeout_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL glitch_width: got %0d/t%0b, want %0d/t0", bl.width_out, bl.timeout_flag,
               GLITCH_W);
    end
    rdy = 1'b1;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_spike();
    int c;
    do_reset();
    fire_arm();
    repeat (5) @(negedge clk);
    pulse(10);
    wait_valid(1'b1, 1200, c);
    n_cmp++;
    if (bs.width_out !== 32'(SPIKE_W) || bs.timeout_flag !== SPIKE_TO) begin
      n_bad++;
      $display("FAIL spike: got %0d/t%0b, want %0d/t%0b", bs.width_out, bs.timeout_flag,
               SPIKE_W, SPIKE_TO);
    end
  endtask

  task automatic test_timeout_low();
    int c;
    do_reset();
    fire_arm();
    wait_valid(1'b1, 1100, c);
    n_cmp++;
    if (c !== 1000) begin
      n_bad++; $display("FAIL no_rise_latency: got %0d cycles want 1000", c);
    end
    n_cmp++;
    if (bs.width_out !== 32'd0 || bs.timeout_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL no_rise_result: got %0d/t%0b, want 0/t1", bs.width_out, bs.timeout_flag);
    end
  endtask

  task automatic test_timeout_high();
    int c;
    do_reset();
    fire_arm();
    repeat (20) @(negedge clk);
    echo = 1'b1;
    wait_valid(1'b1, 1200, c);
    n_cmp++;
    if (bs.width_out !== 32'd1000 || bs.timeout_flag !== 1'b1) begin
      n_bad++;
      $display("FAIL long_pulse: got %0d/t%0b, want 1000/t1", bs.width_out, bs.timeout_flag);
    end
    repeat (2000 - c) @(negedge clk);
    echo = 1'b0;
    repeat (40) @(negedge clk);
  endtask

  task automatic test_high_at_arm();
    int c;
    do_reset();
    echo = 1'b1;
    repeat (30) @(negedge clk);
    fire_arm();
    repeat (50) @(negedge clk);
    echo = 1'b0;
    repeat (40) @(negedge clk);
    pulse(200);
    wait_valid(1'b0, 100, c);
    n_cmp++;
    if (bl.width_out !== 32'd200 || bl.timeout_flag !== 1'b0) begin
      n_bad++;
      $display("FAIL high_at_arm: got %0d/t%0b, want 200/t0", bl.width_out, bl.timeout_flag);
    end
  endtask

  task automatic test_hold();
    int c;
    int bad;
    do_reset();
    rdy = 1'b0;
    fire_arm();
    repeat (TRIG_CYC) @(negedge clk);
    pulse(300);
    wait_valid(1'b0, 100, c);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      arm  = (i % 10 == 0);
      echo = (i >= 20 && i < 30);
      @(negedge clk);
      if (!(bl.result_valid === 1'b1 && bl.width_out === 32'd300 && bl.timeout_flag === 1'b0))
        bad++;
    end
    arm = 1'b0;
    echo = 1'b0;
    n_cmp++;
    if (bad !== 0) begin
      n_bad++; $display("FAIL hold_stable: %0d unstable cycles, want 0 (width 300)", bad);
    end
    rdy = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (bl.busy !== 1'b0 || bl.result_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL hold_release: busy %0b valid %0b, want 0 0", bl.busy, bl.result_valid);
    end
    repeat (40) @(negedge clk);
    n_cmp++;
    if (bl.busy !== 1'b0) begin
      n_bad++; $display("FAIL hold_arm_ignored: busy %0b, want 0", bl.busy);
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_reset_mid_measure();
    test_basic();
    test_glitch();
    test_spike();
    test_timeout_low();
    test_timeout_high();
    test_high_at_arm();
    test_hold();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/echo_capture.md
# echo_capture

Conditions the raw ultrasonic echo input and measures one echo pulse per trigger, returning the width in clock cycles through a valid/ready handshake. Sits directly downstream of the trigger generator, which pulses `arm` once per ranging cycle, and upstream of the distance/LED decision logic. Replaces free-running width counting with a synchronized, glitch-filtered, timeout-bounded measurement, so an unstable sensor cannot reset a measurement mid-pulse.

## Interface
- CLK_HZ, 27_000_000, system clock frequency (documentation only; 10 µs = 270 cycles)
- WIDTH_W, 32, width of the measurement counter and `width_out`; must hold TIMEOUT_CYC
- FILTER_LEN, 16, consecutive agreeing samples required before `echo_clean` changes (≥1)
- TIMEOUT_CYC, 1_000_000, maximum cycles spent waiting for a rise or measuring a high pulse

- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- echo_pin  in  1  raw sensor echo, asynchronous to clk
- arm  in  1  single-cycle start pulse from the trigger generator
- result_ready  in  1  consumer accepts the result
- result_valid  out  1  result held on `width_out` / `timeout_flag`
- width_out  out  WIDTH_W  measured high time of `echo_clean`, in cycles
- timeout_flag  out  1  result is a timeout (no rise, or pulse too long)
- busy  out  1  a measurement is in progress or a result is pending
- echo_clean  out  1  synchronized, filtered echo, for observation

## Operation
- Input path: 2-flop synchronizer on `echo_pin`, then the optional glitch filter, giving `echo_clean`; a registered copy provides rise/fall detection.
- States: IDLE, WAIT_RISE, MEASURE, HOLD.
- IDLE: `busy`=0. `arm`=1 → WAIT_RISE, counter cleared to 0.
- WAIT_RISE: counter +1 per cycle. `echo_clean` rise detected → MEASURE, counter reloaded to 1. Counter reaches TIMEOUT_CYC with no rise → HOLD, `width_out`=0, `timeout_flag`=1.
- MEASURE: counter +1 for each cycle `echo_clean`=1. Fall detected → HOLD, `width_out`=counter, `timeout_flag`=0. Counter reaches TIMEOUT_CYC while high → HOLD, `width_out`=TIMEOUT_CYC, `timeout_flag`=1.
- HOLD: `result_valid`=1, with `width_out` and `timeout_flag` stable. `result_ready`=1 → IDLE the next cycle.
- `arm` outside IDLE is ignored and does not restart the measurement.
- If `echo_clean` is already high when `arm` arrives, WAIT_RISE still requires a genuine rise; that pulse is not measured.
- The counter saturates at TIMEOUT_CYC and never wraps.

## Timing
- Reset values: `result_valid`=0, `width_out`=0, `timeout_flag`=0, `busy`=0, `echo_clean`=0, state IDLE, synchronizer and filter flops 0.
- `arm` in cycle t → `busy`=1 in cycle t+1.
- `echo_clean` follows a clean `echo_pin` edge after 2+FILTER_LEN cycles with the filter, or 2 cycles without it. Both edges see the same delay, so a clean pulse of P cycles gives `width_out`=P.
- `result_valid` rises the cycle after the fall is detected, and stays high until the first cycle it is sampled together with `result_ready`=1.
- Zero-wait acceptance: `result_ready` held at 1 means one HOLD cycle.
- Reset asserted mid-measurement returns all outputs to their reset values immediately; no partial result is produced.

## Configuration
- `ECHO_GLITCH_FILTER_EN` defined: `echo_clean` changes only after the synchronized input differs from it for FILTER_LEN consecutive cycles. Any disagreement shorter than that is discarded and the run counter clears.
- Not defined: `echo_clean` is the synchronizer output directly. FILTER_LEN is unused and input latency is 2 cycles.

## Structure
- Package `echo_pkg`: state enum `echo_state_t` (IDLE, WAIT_RISE, MEASURE, HOLD) and a shared constant for the 10 µs trigger length (270 cycles at 27 MHz).
- Sub-module `echo_glitch_filter` (parameter FILTER_LEN; ports clk, rst, d, q) holds the run counter. It is instantiated only under `ECHO_GLITCH_FILTER_EN`.

## Test plan
- Reset mid-MEASURE (width counter at 500) → all outputs 0 on assertion; after release, the next `arm` plus a 1000-cycle pulse → `width_out`=1000.
- `arm`, then 20 cycles later a clean 5400-cycle echo pulse, `result_ready`=1 → `result_valid` for 1 cycle, `width_out`=5400, `timeout_flag`=0.
- Filter enabled (FILTER_LEN=16): 5000-cycle pulse with 3-cycle low glitches every 700 cycles → one result with `width_out`=5000. Separately, a lone 10-cycle high spike after `arm` → no rise, timeout after TIMEOUT_CYC.
- `arm` with echo held low, TIMEOUT_CYC=1000 → `result_valid` at 1000 cycles after `busy` rises, `width_out`=0, `timeout_flag`=1.
- Echo held high for 2000 cycles, TIMEOUT_CYC=1000 → `width_out`=1000, `timeout_flag`=1.
- `result_ready`=0 for 50 cycles, with `arm` pulses during HOLD → `result_valid` and `width_out` stable throughout, extra `arm` ignored; `result_ready`=1 → IDLE, `busy`=0 the next cycle.
